// File: rtl/regfile_pkg.sv
// Shared sizing for the register-file write-back path.
package regfile_pkg;
  localparam int RF_XLEN       = 64;
  localparam int RF_AW         = 5;
  localparam int RF_NREGS      = 32;
  localparam int RF_FIFO_DEPTH = 2;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {SEL_NONE, SEL_WB, SEL_FIFO} wbSel_e;

  // One-hot mask for a register; register 0 is never tracked.
  function automatic logic [RF_NREGS-1:0] regMask(input logic [RF_AW-1:0] r);
    return (r == '0) ? '0 : (RF_NREGS'(1) << r);
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Multi-cycle result handshake: producer offers, arbiter accepts on valid&ready.
interface regfile_wb_arbiter_if
  import regfile_pkg::*;
#(
  parameter int XLEN = RF_XLEN
);
  logic             mc_valid;
  logic [RF_AW-1:0] mc_rd;
  logic [XLEN-1:0]  mc_data;
  logic             mc_ready;

  modport master (output mc_valid, mc_rd, mc_data, input mc_ready);
  modport slave  (input mc_valid, mc_rd, mc_data, output mc_ready);
endinterface

// File: rtl/wb_fifo.sv
// Small circular buffer holding multi-cycle results until the write port is free.
module wb_fifo #(
  parameter int DW    = 69,
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] pushData,
  input  logic          pop,
  output logic [DW-1:0] popData,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic          doPush, doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline write-back and
// buffered multi-cycle results, and tracks registers awaiting those results.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN       = RF_XLEN,
  parameter int FIFO_DEPTH = RF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  input  logic [RF_AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                mc_issue,
  input  logic [RF_AW-1:0]    mc_issue_rd,
  regfile_wb_arbiter_if.slave mc,
  input  logic [RF_AW-1:0]    id_rs1,
  input  logic [RF_AW-1:0]    id_rs2,
  input  logic [RF_AW-1:0]    id_rd,
  output logic                stall,
  output logic                RegWrite,
  output logic [RF_AW-1:0]    WriteReg,
  output logic [XLEN-1:0]     WriteData,
  output logic [RF_NREGS-1:0] busy,
  output logic                err
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [RF_AW+XLEN-1:0] headEntry;
  logic [RF_AW-1:0]      headRd;
  logic [XLEN-1:0]       headData;
  logic [CW-1:0]         fifoCount;
  logic                  fifoFull, fifoEmpty, fifoPush, fifoPop;
  wbSel_e                sel;
  logic [RF_AW-1:0]      selRd;
  logic [XLEN-1:0]       selData;
  logic [RF_NREGS-1:0]   clrMask, setMask, busyNext;
  logic                  issueReq, issueHit, errNext;

  assign {headRd, headData} = headEntry;
  assign mc.mc_ready        = (fifoCount < CW'(FIFO_DEPTH));
  assign fifoPush           = mc.mc_valid && !fifoFull;

  wb_fifo #(.DW(RF_AW + XLEN), .DEPTH(FIFO_DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifoPush),
    .pushData ({mc.mc_rd, mc.mc_data}),
    .pop      (fifoPop),
    .popData  (headEntry),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Fixed priority: pipeline write-back never waits, the buffer drains when idle.
  always_comb begin
    sel     = SEL_NONE;
    selRd   = '0;
    selData = '0;
    fifoPop = 1'b0;
    if (wb_valid) begin
      sel     = SEL_WB;
      selRd   = wb_rd;
      selData = wb_data;
    end else if (!fifoEmpty) begin
      sel     = SEL_FIFO;
      selRd   = headRd;
      selData = headData;
      fifoPop = 1'b1;
    end
  end

  // Scoreboard update; a re-issue racing its own retiring result counts as legal.
  always_comb begin
    clrMask  = fifoPop ? regMask(headRd) : '0;
    issueReq = mc_issue && (mc_issue_rd != '0);
    issueHit = busy[mc_issue_rd] && !clrMask[mc_issue_rd];
    setMask  = (issueReq && !issueHit) ? regMask(mc_issue_rd) : '0;
    busyNext = (busy & ~clrMask) | setMask;
    errNext  = err
             | (issueReq && issueHit)
             | (wb_valid && busy[wb_rd])
             | (fifoPop && !busy[headRd]);
  end

  assign stall = busy[id_rs1] | busy[id_rs2] | busy[id_rd];

  // Registered write port; writes to register 0 are consumed but suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= (sel != SEL_NONE) && (selRd != '0);
      if (sel != SEL_NONE) begin
        WriteReg  <= selRd;
        WriteData <= selData;
      end
    end
  end

  // Busy vector and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busyNext;
      err  <= errNext;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: a reference model predicts each register-file write,
// queues it, and the negedge monitor pops and compares.
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 64;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_valid, mc_issue;
  logic [4:0]      wb_rd, mc_issue_rd, id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall, RegWrite, err;
  logic [4:0]      WriteReg;
  logic [XLEN-1:0] WriteData;
  logic [31:0]     busy;

  int nPass = 0;
  int nChecks = 0;

  typedef struct {logic [4:0] rd; logic [XLEN-1:0] data;} wr_t;
  wr_t expQ[$];
  wr_t mcModel[$];

  regfile_wb_arbiter_if #(.XLEN(XLEN)) mcIf ();

  regfile_wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
    .mc(mcIf.slave),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .stall(stall), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: selection, buffering and acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      expQ.delete();
      mcModel.delete();
    end else begin
      automatic bit acc = mcIf.mc_valid && (mcModel.size() < DEPTH);
      automatic wr_t e;
      if (wb_valid) begin
        if (wb_rd != 0) expQ.push_back('{wb_rd, wb_data});
      end else if (mcModel.size() > 0) begin
        e = mcModel.pop_front();
        if (e.rd != 0) expQ.push_back(e);
      end
      if (acc) mcModel.push_back('{mcIf.mc_rd, mcIf.mc_data});
    end
  end

  // Output monitor, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("mc_ready", mcIf.mc_ready, mcModel.size() < DEPTH);
      if (RegWrite || expQ.size() > 0) begin
        chk("RegWrite", RegWrite, expQ.size() > 0);
        if (expQ.size() > 0) begin
          automatic wr_t e = expQ.pop_front();
          chk("WriteReg", WriteReg, e.rd);
          chk("WriteData", WriteData, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    mc_issue = 0; mc_issue_rd = 0;
    mcIf.mc_valid = 0; mcIf.mc_rd = 0; mcIf.mc_data = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
  endtask

  task automatic issue(input logic [4:0] r);
    mc_issue = 1; mc_issue_rd = r;
    step();
    mc_issue = 0; mc_issue_rd = 0;
  endtask

  task automatic offer(input logic [4:0] r, input logic [XLEN-1:0] d);
    mcIf.mc_valid = 1; mcIf.mc_rd = r; mcIf.mc_data = d;
    step();
    mcIf.mc_valid = 0;
  endtask

  initial begin
    int nextMc;
    bit acc;
    rst = 1;
    idle();
    step(); step();
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_mc_ready", mcIf.mc_ready, 1);
    chk("rst_stall", stall, 0);
    rst = 0;
    step();

    // Plain pipeline write-back.
    wb_valid = 1; wb_rd = 5; wb_data = 64'hAB;
    step();
    wb_valid = 0;
    step();

    // Issue, stall on dependency, retire through the buffer.
    issue(7);
    id_rs1 = 7;
    #1;
    chk("busy7_set", busy[7], 1);
    chk("stall_rs1", stall, 1);
    offer(7, 64'h11);
    step();
    chk("busy7_clr", busy[7], 0);
    chk("stall_clr", stall, 0);
    id_rs1 = 0;
    step();

    // Buffer fills while write-back holds the port, then drains in order.
    issue(10); issue(11); issue(12);
    nextMc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      wb_valid = (cyc < 4); wb_rd = 5'(cyc + 1); wb_data = 64'h100 + 64'(cyc);
      if (nextMc < 3) begin
        mcIf.mc_valid = 1; mcIf.mc_rd = 5'(10 + nextMc); mcIf.mc_data = 64'h200 + 64'(nextMc);
      end else mcIf.mc_valid = 0;
      #1;
      if (cyc == 2) chk("mc_ready_full", mcIf.mc_ready, 0);
      acc = mcIf.mc_valid && mcIf.mc_ready;
      step();
      if (acc) nextMc++;
    end
    idle();
    chk("all_mc_accepted", nextMc, 3);
    chk("busy_drained", busy, 0);
    chk("err_clean", err, 0);

    // Retire and re-issue the same register on one edge.
    issue(9);
    offer(9, 64'h99);
    issue(9);
    chk("busy9_reissue", busy[9], 1);
    chk("err_reissue", err, 0);
    offer(9, 64'h9A);
    step();
    chk("busy9_final", busy, 0);

    // Issue to an already-busy register, then to register 0.
    issue(3);
    issue(3);
    chk("err_double_issue", err, 1);
    chk("busy_double_issue", busy, 32'h8);
    issue(0);
    chk("busy_r0", busy, 32'h8);
    chk("err_sticky", err, 1);

    // Reset mid-cycle with two buffered results.
    issue(20); issue(21);
    wb_valid = 1; wb_rd = 1; wb_data = 64'h55;
    offer(20, 64'h20);
    offer(21, 64'h21);
    #2 rst = 1;
    #1;
    chk("mid_rst_RegWrite", RegWrite, 0);
    chk("mid_rst_WriteReg", WriteReg, 0);
    chk("mid_rst_WriteData", WriteData, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_mc_ready", mcIf.mc_ready, 1);
    idle();
    step();
    rst = 0;
    for (int i = 0; i < 5; i++) step();
    chk("post_rst_RegWrite", RegWrite, 0);
    chk("post_rst_mc_ready", mcIf.mc_ready, 1);
    chk("expQ_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
